// File: rtl/if_stage_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned InstAddrBus = 16;
  localparam int unsigned InstBus     = 16;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  localparam inst_t      NopInst      = 16'h0800;
  localparam inst_addr_t ResetPc      = 16'h0000;
  localparam logic       StallYes     = 1'b1;
  localparam logic       BranchFlagUp = 1'b1;

  typedef enum logic [0:0] {
    StFetch,
    StHold
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-port handshake between the fetch stage and the shared-memory arbiter.
interface if_stage_if;
  import if_stage_pkg::*;

  logic       req;
  inst_addr_t addr;
  logic       ack;
  inst_t      rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/if_stage.sv
// Fetch stage: owns the fetch PC, buffers one word while decode stalls, applies
// single-delay-slot branch redirects and drives the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = ResetPc,
  parameter inst_t      NOP_INST = NopInst
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_addr_i,
  if_stage_if.master imem,
  output inst_addr_t pc_o,
  output inst_t      inst_o,
  output logic       inst_valid_o
);

  if_state_e  state_q, state_d;
  inst_addr_t fpc_q, fpc_d;
  inst_addr_t buf_pc_q, buf_pc_d;
  inst_t      buf_inst_q, buf_inst_d;
  logic       redirect_pend_q, redirect_pend_d;
  inst_addr_t redirect_addr_q, redirect_addr_d;
  inst_addr_t pc_q, pc_d;
  inst_t      inst_q, inst_d;
  logic       valid_q, valid_d;

  logic       stall;
  logic       branch_take;
  inst_addr_t fpc_inc;
  inst_addr_t nxt_pc;

  assign stall   = (stall_i == StallYes);
  assign fpc_inc = fpc_q + inst_addr_t'(1);

  // A branch only counts when decode actually consumes the instruction in IF/ID.
  assign branch_take = (branch_flag_i == BranchFlagUp) && valid_q && !stall && !redirect_pend_q;

  always_comb begin
    nxt_pc = fpc_inc;
    if (redirect_pend_q) begin
      nxt_pc = redirect_addr_q;
    end else if (branch_take) begin
      nxt_pc = branch_addr_i;
    end
  end

  always_comb begin
    state_d         = state_q;
    fpc_d           = fpc_q;
    buf_pc_d        = buf_pc_q;
    buf_inst_d      = buf_inst_q;
    redirect_pend_d = redirect_pend_q;
    redirect_addr_d = redirect_addr_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    valid_d         = valid_q;

    unique case (state_q)
      StFetch: begin
        if (imem.ack) begin
          // The acked word is the delay slot of any pending or same-cycle branch.
          fpc_d           = nxt_pc;
          redirect_pend_d = 1'b0;
          if (stall) begin
            buf_pc_d   = fpc_inc;
            buf_inst_d = imem.rdata;
            state_d    = StHold;
          end else begin
            pc_d    = fpc_inc;
            inst_d  = imem.rdata;
            valid_d = 1'b1;
          end
        end else begin
          if (branch_take) begin
            redirect_pend_d = 1'b1;
            redirect_addr_d = branch_addr_i;
          end
          if (!stall) begin
            pc_d    = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          pc_d       = buf_pc_q;
          inst_d     = buf_inst_q;
          valid_d    = 1'b1;
          buf_pc_d   = '0;
          buf_inst_d = NOP_INST;
          state_d    = StFetch;
          // Buffered word is the delay slot and nothing is in flight.
          if (branch_take) begin
            fpc_d = branch_addr_i;
          end
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StFetch;
      fpc_q           <= RESET_PC;
      buf_pc_q        <= '0;
      buf_inst_q      <= NOP_INST;
      redirect_pend_q <= 1'b0;
      redirect_addr_q <= '0;
      pc_q            <= '0;
      inst_q          <= NOP_INST;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      fpc_q           <= fpc_d;
      buf_pc_q        <= buf_pc_d;
      buf_inst_q      <= buf_inst_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_addr_q <= redirect_addr_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
      valid_q         <= valid_d;
    end
  end

  // Request drops combinationally with reset so the arbiter abandons it at once.
  assign imem.req  = rst && (state_q == StFetch);
  assign imem.addr = fpc_q;

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage with a program-order reference model of fetched words.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [15:0] branch_addr_i = 16'h0000;
  logic [15:0] pc_o;
  logic [15:0] inst_o;
  logic        inst_valid_o;

  if_stage_if imem ();

  if_stage #(
    .RESET_PC(16'h0000),
    .NOP_INST(16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .imem         (imem),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int errors = 0;
  int checks = 0;

  // Model: acked words not yet consumed by decode, in program order.
  typedef struct {
    int          idx;
    logic [15:0] pc;
    logic [15:0] inst;
  } word_t;

  word_t       q[$];
  bit          m_valid = 1'b0;
  int          n_acks = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] redirect[int];

  // Address the n-th fetch must use: sequential, or a branch target two words after the branch.
  function automatic logic [15:0] exp_addr();
    if (redirect.exists(n_acks)) return redirect[n_acks];
    if (n_acks == 0) return 16'h0000;
    return last_addr + 16'd1;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_valid = 1'b0;
      n_acks = 0;
      last_addr = 16'h0000;
      redirect.delete();
    end else begin
      logic [15:0] a;
      if (!stall_i && m_valid) begin
        if (branch_flag_i) redirect[q[0].idx + 2] = branch_addr_i;
        void'(q.pop_front());
      end
      if (imem.ack) begin
        a = exp_addr();
        q.push_back('{n_acks, a + 16'd1, mem[a]});
        last_addr = a;
        n_acks++;
      end
      if (!stall_i) m_valid = (q.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      int held;
      held = q.size() - (m_valid ? 1 : 0);
      check("req", 16'(imem.req), 16'(held == 0));
      check("valid", 16'(inst_valid_o), 16'(m_valid));
      if (m_valid) begin
        check("pc", pc_o, q[0].pc);
        check("inst", inst_o, q[0].inst);
      end else begin
        check("bubble_pc", pc_o, 16'h0000);
        check("bubble_inst", inst_o, 16'h0800);
      end
      if (imem.req) check("addr", imem.addr, exp_addr());
    end
  end

  task automatic drive(input bit ack_en, input bit st, input bit br, input logic [15:0] ba);
    stall_i       = st;
    branch_flag_i = br;
    branch_addr_i = ba;
    imem.ack      = ack_en && imem.req;
    imem.rdata    = imem.ack ? mem[imem.addr] : 16'($urandom);
  endtask

  function automatic logic [15:0] pick_target();
    unique case ($urandom_range(0, 3))
      0: return 16'hFFFF;
      1: return 16'hFFFE;
      2: return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic random_run(input int cycles);
    int ack_p, st_p, br_p;
    for (int c = 0; c < cycles; c++) begin
      if (c % 400 == 0) begin
        ack_p = $urandom_range(20, 100);
        st_p  = $urandom_range(0, 50);
        br_p  = $urandom_range(0, 40);
      end
      @(negedge clk);
      #1;
      drive($urandom_range(0, 99) < ack_p, $urandom_range(0, 99) < st_p,
            $urandom_range(0, 99) < br_p, pick_target());
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rel_req", 16'(imem.req), 16'h0001);
    check("rel_addr", imem.addr, 16'h0000);
    check("rel_valid", 16'(inst_valid_o), 16'h0000);
    check("rel_inst", inst_o, 16'h0800);
    check("rel_pc", pc_o, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4801;
    mem[1] = 16'h4902;
    mem[2] = 16'h0800;
    mem[3] = 16'h6A05;
    imem.ack   = 1'b0;
    imem.rdata = 16'h0000;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 16'(imem.req), 16'h0000);

    // Zero-wait streaming from reset, then a branch to 0xFFFF taken with a same-cycle ack.
    release_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    check("lit_pc1", pc_o, 16'h0001);
    check("lit_inst1", inst_o, 16'h4801);
    check("lit_valid1", 16'(inst_valid_o), 16'h0001);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    check("lit_pc2", pc_o, 16'h0002);
    check("lit_inst2", inst_o, 16'h4902);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    check("lit_pc3", pc_o, 16'h0003);
    check("lit_inst3", inst_o, 16'h0800);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    check("lit_pc4", pc_o, 16'h0004);
    check("lit_inst4", inst_o, 16'h6A05);
    check("lit_addr4", imem.addr, 16'h0004);
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF);
    @(negedge clk); #1;
    check("lit_slot_pc", pc_o, 16'h0005);
    check("lit_slot_inst", inst_o, mem[4]);
    check("lit_tgt_addr", imem.addr, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1;
    check("lit_wrap_pc", pc_o, 16'h0000);
    check("lit_wrap_valid", 16'(inst_valid_o), 16'h0001);
    check("lit_wrap_addr", imem.addr, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    random_run(4000);

    // Get a request outstanding, then pulse reset in the middle of it.
    repeat (3) begin
      @(negedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
    end
    check("pre_rst_req", 16'(imem.req), 16'h0001);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", 16'(imem.req), 16'h0000);
    check("mid_rst_valid", 16'(inst_valid_o), 16'h0000);
    check("mid_rst_inst", inst_o, 16'h0800);
    check("mid_rst_pc", pc_o, 16'h0000);
    imem.ack = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    random_run(1500);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
